wt_inval_queue: RTL and testbench
=================================

Name: wt_inval_queue

Overview:
- Invalidation scheduler between the coherence network and the cache subsystem's single invalidation port (address / valid / ready).
- Buffers incoming invalidation addresses in a small FIFO and line-aligns them.
- Coalesces duplicates of not-yet-issued lines.
- Withholds new issues while a D$ flush is in progress, and discards queued work when the flush completes (the whole cache is then empty).

Parameters:
- Depth, 4, number of queue entries (power of two, >=2)
- AddrWidth, 64, invalidation address width
- LineOffsetWidth, 4, log2 of D$ line bytes (tie to DCACHE_OFFSET_WIDTH)
- CntWidth, 16, width of statistics counters

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- in_addr_i  in  AddrWidth  invalidation address from network
- in_valid_i  in  1  request valid
- in_ready_o  out  1  queue can accept
- out_addr_o  out  AddrWidth  line-aligned address to cache subsystem
- out_valid_o  out  1  invalidation presented
- out_ready_i  in  1  cache subsystem accepts
- flush_i  in  1  D$ flush in progress (high until acknowledged)
- flush_ack_i  in  1  single-cycle flush-complete pulse
- level_o  out  $clog2(Depth)+1  occupied entries
- coalesce_cnt_o  out  CntWidth  coalesced requests
- drop_cnt_o  out  CntWidth  requests discarded by flush

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: out_valid_o=0, out_addr_o=0, level_o=0, in_ready_o=1 after reset, both counters 0. Reset mid-operation discards all entries, including one being presented.
- Accept and ready: accept = in_valid_i & in_ready_o. in_ready_o = (level < Depth), with no combinational path from out_ready_i. A full queue popping in the same cycle still deasserts in_ready_o.
- Line alignment: the stored line tag is in_addr_i[AddrWidth-1:LineOffsetWidth]. out_addr_o = {tag, LineOffsetWidth zeros}.
- Coalescing: an accepted request whose tag equals any valid entry other than the presented head is dropped, and coalesce_cnt increments. The presented head never coalesces, because the invalidation must reissue after it. Comparison uses entry state before this cycle's pop.
- Output register: the head is registered.
  - Enqueue into an empty queue gives out_valid_o=1 on the next cycle (1-cycle latency).
  - Pop on out_valid_o & out_ready_i. The next entry appears the following cycle, so back-to-back pops give one issue per cycle.
  - Once out_valid_o=1, it and out_addr_o stay stable until the handshake.
- FSM (output side):
  - IDLE: queue empty or flush_i=1 -> out_valid_o=0.
  - PRESENT: out_valid_o=1. Stays until handshake, then goes to PRESENT if more entries and flush_i=0, else IDLE.
  - flush_i only blocks IDLE->PRESENT. It never retracts a presented entry.
- Flush completion: on flush_ack_i, clear every entry except a presented, unaccepted head. The head is also cleared if its handshake occurs that cycle.
  - drop_cnt increments by the number of entries cleared.
  - A request accepted in the same cycle is discarded and counted in drop_cnt as well.
- Simultaneous push and pop: level unchanged; FIFO order preserved.
- Wrap-around: read/write pointers are modulo Depth; level is tracked separately to disambiguate full/empty.
- Counters saturate at all-ones and never wrap.

Optional Feature:
- Macro: WT_INVAL_STATS_EN
- Defined: coalesce_cnt_o and drop_cnt_o count as specified.
- Undefined: the counters are not instantiated, both ports are driven constant 0, and queue behaviour is unchanged.

Decomposition:
- wt_cache_pkg gets inval_entry_t (valid bit plus line tag) and the INVAL_QUEUE_DEPTH default.
- The tag comparison is a pure function defined in the package.
- No sub-module: a single flat module.

Test Plan:
- Reset, then push 0x1234 -> out_valid_o=1 next cycle, out_addr_o=0x1230. With out_ready_i=1, the queue empties and level_o=0.
- Hold out_ready_i=0, push 0x100, 0x200, 0x204, 0x300, 0x400 -> 0x204 coalesces (coalesce_cnt_o=1). After 0x400, in_ready_o=0. Release ready -> order 0x100, 0x200, 0x300, 0x400 on consecutive cycles.
- Head 0x500 presented, not accepted; push 0x508 -> enqueued, not coalesced. Two 0x500 issues occur.
- flush_i=1 with empty queue, push 0x600 -> out_valid_o stays 0. flush_ack_i pulse -> entry dropped, drop_cnt_o=1, out_valid_o never rises.
- Head 0x700 presented, two more queued, flush_ack_i pulses with out_ready_i=0 -> 0x700 stays valid and stable. Queue level 1, drop_cnt_o=2.
- Assert rst_i while full and presenting -> next cycle out_valid_o=0, level_o=0, in_ready_o=1, counters 0.

Source files
------------

// File: rtl/wt_cache_pkg.sv
// Shared cache-subsystem types for the invalidation path: queue entry layout,
// default queue depth, line offset width and the line-tag comparison.
package wt_cache_pkg;

    localparam int unsigned DCACHE_OFFSET_WIDTH = 4;
    localparam int unsigned INVAL_QUEUE_DEPTH   = 4;
    localparam int unsigned INVAL_ADDR_WIDTH    = 64;
    localparam int unsigned INVAL_TAG_WIDTH     = INVAL_ADDR_WIDTH - DCACHE_OFFSET_WIDTH;

    typedef logic [INVAL_TAG_WIDTH-1:0] inval_tag_t;

    typedef struct packed {
        logic       valid;
        inval_tag_t tag;
    } inval_entry_t;

    typedef enum logic {
        INVAL_IDLE    = 1'b0,
        INVAL_PRESENT = 1'b1
    } inval_state_e;

    // True when the entry holds a live request for the same cache line.
    function automatic logic inval_tag_hit(input inval_entry_t entry, input inval_tag_t tag);
        return entry.valid && (entry.tag == tag);
    endfunction

endpackage

// File: rtl/wt_inval_queue.sv
// Invalidation scheduler: line-aligning, coalescing FIFO with a registered head and flush gating.
// Optional statistics counters are built only when WT_INVAL_STATS_EN is defined.
module wt_inval_queue
    import wt_cache_pkg::*;
#(
    parameter int unsigned Depth           = INVAL_QUEUE_DEPTH,
    parameter int unsigned AddrWidth       = INVAL_ADDR_WIDTH,
    parameter int unsigned LineOffsetWidth = DCACHE_OFFSET_WIDTH,
    parameter int unsigned CntWidth        = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [AddrWidth-1:0]     in_addr_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    output logic [AddrWidth-1:0]     out_addr_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    input  logic                     flush_i,
    input  logic                     flush_ack_i,
    output logic [$clog2(Depth):0]   level_o,
    output logic [CntWidth-1:0]      coalesce_cnt_o,
    output logic [CntWidth-1:0]      drop_cnt_o
);

    localparam int unsigned PtrW   = $clog2(Depth);
    localparam int unsigned LevelW = PtrW + 1;
    localparam int unsigned TagW   = AddrWidth - LineOffsetWidth;
    localparam logic [LevelW-1:0] DepthLvl = LevelW'(Depth);

    inval_entry_t          r_entries [Depth];
    logic [PtrW-1:0]       r_rd_ptr;
    logic [PtrW-1:0]       r_wr_ptr;
    logic [LevelW-1:0]     r_level;
    inval_state_e          r_state;
    logic                  r_out_valid;
    logic [AddrWidth-1:0]  r_out_addr;

    inval_tag_t            w_in_tag;
    inval_tag_t            w_head_tag_next;
    logic                  w_accept;
    logic                  w_pop;
    logic                  w_hit;
    logic                  w_coalesce;
    logic                  w_push;
    logic                  w_keep_head;
    logic                  w_present_next;
    logic [LevelW-1:0]     w_level_after_pop;
    logic [LevelW-1:0]     w_level_next;
    logic [LevelW-1:0]     w_drop_n;
    logic [PtrW-1:0]       w_rd_ptr_next;
    logic [PtrW-1:0]       w_wr_ptr_next;
    logic [LineOffsetWidth-1:0] w_unused_offset;

    assign w_in_tag        = inval_tag_t'(in_addr_i[AddrWidth-1:LineOffsetWidth]);
    assign w_unused_offset = in_addr_i[LineOffsetWidth-1:0];

    assign in_ready_o  = (r_level < DepthLvl);
    assign out_valid_o = r_out_valid;
    assign out_addr_o  = r_out_addr;
    assign level_o     = r_level;

    assign w_accept    = in_valid_i & in_ready_o;
    assign w_pop       = r_out_valid & out_ready_i;
    assign w_keep_head = r_out_valid & ~out_ready_i;

    // The presented head is excluded: its invalidation must still be reissued afterwards.
    always_comb begin
        // NOTE: every combinational signal gets a default first so no path can infer a latch.
        w_hit = 1'b0;
        for (int unsigned i = 0; i < Depth; i++) begin
            if (!(r_out_valid && (PtrW'(i) == r_rd_ptr)) && inval_tag_hit(r_entries[i], w_in_tag)) begin
                w_hit = 1'b1;
            end
        end
    end

    // A flush completion swallows any request accepted in the same cycle.
    assign w_coalesce = w_accept & w_hit & ~flush_ack_i;
    assign w_push     = w_accept & ~w_hit & ~flush_ack_i;

    assign w_level_after_pop = r_level - LevelW'(w_pop);
    assign w_rd_ptr_next     = r_rd_ptr + PtrW'(w_pop);

    always_comb begin
        w_level_next  = w_level_after_pop + LevelW'(w_push);
        w_wr_ptr_next = r_wr_ptr + PtrW'(w_push);
        w_drop_n      = '0;
        if (flush_ack_i) begin
            w_level_next  = LevelW'(w_keep_head);
            w_wr_ptr_next = r_rd_ptr + PtrW'(r_out_valid);
            w_drop_n      = r_level - LevelW'(r_out_valid) + LevelW'(w_accept);
        end
    end

    // When nothing remains behind a pop, the next head is the request arriving this cycle.
    assign w_head_tag_next = (w_level_after_pop == '0) ? w_in_tag : r_entries[w_rd_ptr_next].tag;
    assign w_present_next  = w_keep_head | (~flush_i & (w_level_next != '0));

    always_ff @(posedge clk_i) begin
        // NOTE: only the valid bits are reset; tags are don't-care until their entry is written.
        if (rst_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                r_entries[i].valid <= 1'b0;
            end
        end else if (flush_ack_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                if (!(w_keep_head && (PtrW'(i) == r_rd_ptr))) begin
                    r_entries[i].valid <= 1'b0;
                end
            end
        end else begin
            if (w_pop) begin
                r_entries[r_rd_ptr].valid <= 1'b0;
            end
            if (w_push) begin
                r_entries[r_wr_ptr] <= '{valid: 1'b1, tag: w_in_tag};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_rd_ptr <= w_rd_ptr_next;
            r_wr_ptr <= w_wr_ptr_next;
            r_level  <= w_level_next;
        end
    end

    // Output-side FSM; flush_i only blocks IDLE->PRESENT, never retracts a presented head.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= INVAL_IDLE;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
        end else begin
            case (r_state)
                INVAL_IDLE: begin
                    if (w_present_next) begin
                        r_state     <= INVAL_PRESENT;
                        r_out_valid <= 1'b1;
                        r_out_addr  <= {w_head_tag_next[TagW-1:0], {LineOffsetWidth{1'b0}}};
                    end
                end
                INVAL_PRESENT: begin
                    if (w_pop) begin
                        if (w_present_next) begin
                            r_out_addr <= {w_head_tag_next[TagW-1:0], {LineOffsetWidth{1'b0}}};
                        end else begin
                            r_state     <= INVAL_IDLE;
                            r_out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= INVAL_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef WT_INVAL_STATS_EN
    logic [CntWidth-1:0] r_coalesce_cnt;
    logic [CntWidth-1:0] r_drop_cnt;

    function automatic logic [CntWidth-1:0] sat_add(input logic [CntWidth-1:0] a,
                                                    input logic [CntWidth-1:0] b);
        logic [CntWidth:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CntWidth] ? '1 : sum[CntWidth-1:0];
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_coalesce_cnt <= '0;
            r_drop_cnt     <= '0;
        end else begin
            r_coalesce_cnt <= sat_add(r_coalesce_cnt, CntWidth'(w_coalesce));
            r_drop_cnt     <= sat_add(r_drop_cnt, CntWidth'(w_drop_n));
        end
    end

    assign coalesce_cnt_o = r_coalesce_cnt;
    assign drop_cnt_o     = r_drop_cnt;
`else
    logic w_unused_stats;
    assign w_unused_stats = ^{w_coalesce, w_drop_n};
    assign coalesce_cnt_o = '0;
    assign drop_cnt_o     = '0;
`endif

endmodule

// File: tb/tb_wt_inval_queue.sv
// Self-checking bench for wt_inval_queue: directed scenarios then randomized traffic,
// all compared every cycle against a queue-based reference model.
module tb_wt_inval_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 64;
    localparam int CW    = 16;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] in_addr;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] out_addr;
    logic          out_valid;
    logic          out_ready;
    logic          flush;
    logic          flush_ack;
    logic [2:0]    level;
    logic [CW-1:0] coalesce_cnt;
    logic [CW-1:0] drop_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: in-order list of pending line tags (index 0 is the head).
    logic [59:0] mq[$];
    bit          m_pres;
    int          m_coal;
    int          m_drop;

    always #5 clk = ~clk;

    wt_inval_queue dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .in_addr_i      (in_addr),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .out_addr_o     (out_addr),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .flush_i        (flush),
        .flush_ack_i    (flush_ack),
        .level_o        (level),
        .coalesce_cnt_o (coalesce_cnt),
        .drop_cnt_o     (drop_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_coal();
`ifdef WT_INVAL_STATS_EN
        return m_coal;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_drop();
`ifdef WT_INVAL_STATS_EN
        return m_drop;
`else
        return 0;
`endif
    endfunction

    task automatic compare_all();
        chk("out_valid", out_valid, m_pres);
        chk("level", level, mq.size());
        chk("in_ready", in_ready, mq.size() < DEPTH);
        if (m_pres) chk("out_addr", out_addr, {mq[0], 4'h0});
        chk("coalesce_cnt", coalesce_cnt, exp_coal());
        chk("drop_cnt", drop_cnt, exp_drop());
    endtask

    task automatic model_step(input bit iv, input logic [63:0] ia, input bit ordy,
                              input bit fl, input bit fack);
        logic [59:0] t;
        logic [59:0] keep;
        bit acc, pop, hit;
        t   = ia[63:4];
        acc = iv && (mq.size() < DEPTH);
        pop = m_pres && ordy;
        hit = 0;
        foreach (mq[j]) if (mq[j] == t && !(j == 0 && m_pres)) hit = 1;
        if (fack) begin
            m_drop = m_drop + mq.size() - int'(m_pres) + int'(acc);
            if (m_drop > CMAX) m_drop = CMAX;
            if (m_pres && !pop) begin
                keep = mq[0];
                mq.delete();
                mq.push_back(keep);
            end else begin
                mq.delete();
                m_pres = 0;
            end
        end else begin
            if (pop) begin
                void'(mq.pop_front());
                m_pres = 0;
            end
            if (acc) begin
                if (hit) begin
                    if (m_coal < CMAX) m_coal++;
                end else begin
                    mq.push_back(t);
                end
            end
            if (!m_pres) m_pres = !fl && (mq.size() > 0);
        end
    endtask

    // One clock cycle: apply inputs, check registered outputs, advance model and DUT.
    task automatic cycle(input bit iv, input logic [63:0] ia, input bit ordy,
                         input bit fl, input bit fack);
        rst = 0; in_valid = iv; in_addr = ia; out_ready = ordy; flush = fl; flush_ack = fack;
        compare_all();
        model_step(iv, ia, ordy, fl, fack);
        @(posedge clk); #1;
    endtask

    task automatic reset_cycle();
        rst = 1; in_valid = 0; in_addr = '0; out_ready = 0; flush = 0; flush_ack = 0;
        mq.delete(); m_pres = 0; m_coal = 0; m_drop = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [63:0] exp_order [4];
        logic [63:0] ra;
        bit          rfl;
        int          flen;
        bit          rfack;
        int          prev_drop;

        reset_cycle();
        reset_cycle();
        rst = 0;
        chk("reset_addr", out_addr, 64'h0);
        compare_all();

        // Single request, 1-cycle latency, then drained.
        cycle(1, 64'h1234, 1, 0, 0);
        chk("lat1_valid", out_valid, 1'b1);
        chk("lat1_addr", out_addr, 64'h1230);
        cycle(0, 64'h0, 1, 0, 0);
        chk("drain_level", level, 0);
        cycle(0, 64'h0, 1, 0, 0);

        // Coalescing with a stalled consumer, then back-to-back issue order.
        cycle(1, 64'h100, 0, 0, 0);
        cycle(1, 64'h200, 0, 0, 0);
        cycle(1, 64'h204, 0, 0, 0);
        cycle(1, 64'h300, 0, 0, 0);
        cycle(1, 64'h400, 0, 0, 0);
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_level", level, 4);
`ifdef WT_INVAL_STATS_EN
        chk("coalesce_one", coalesce_cnt, 1);
`endif
        exp_order[0] = 64'h100; exp_order[1] = 64'h200;
        exp_order[2] = 64'h300; exp_order[3] = 64'h400;
        for (int i = 0; i < 4; i++) begin
            chk("issue_order", out_addr, exp_order[i]);
            chk("issue_valid", out_valid, 1'b1);
            cycle(0, 64'h0, 1, 0, 0);
        end
        chk("order_empty", out_valid, 1'b0);

        // Presented head never coalesces.
        cycle(1, 64'h500, 0, 0, 0);
        cycle(1, 64'h508, 0, 0, 0);
        chk("head_nocoal_level", level, 2);
        chk("reissue_a", out_addr, 64'h500);
        cycle(0, 64'h0, 1, 0, 0);
        chk("reissue_b", out_addr, 64'h500);
        chk("reissue_b_valid", out_valid, 1'b1);
        cycle(0, 64'h0, 1, 0, 0);

        // Flush with empty queue: new request is withheld then dropped.
        prev_drop = m_drop;
        cycle(1, 64'h600, 0, 1, 0);
        cycle(0, 64'h0, 1, 1, 0);
        chk("flush_hold_valid", out_valid, 1'b0);
        cycle(0, 64'h0, 1, 1, 1);
        cycle(0, 64'h0, 1, 0, 0);
        chk("flush_drop_valid", out_valid, 1'b0);
        chk("flush_drop_level", level, 0);
`ifdef WT_INVAL_STATS_EN
        chk("flush_drop_cnt", drop_cnt, prev_drop + 1);
`endif

        // Flush completion keeps a presented, unaccepted head.
        prev_drop = m_drop;
        cycle(1, 64'h700, 0, 0, 0);
        cycle(1, 64'h710, 0, 0, 0);
        cycle(1, 64'h720, 0, 1, 0);
        cycle(0, 64'h0, 0, 1, 1);
        chk("keep_head_valid", out_valid, 1'b1);
        chk("keep_head_addr", out_addr, 64'h700);
        chk("keep_head_level", level, 1);
`ifdef WT_INVAL_STATS_EN
        chk("keep_head_drop", drop_cnt, prev_drop + 2);
`endif
        cycle(0, 64'h0, 1, 0, 0);
        cycle(0, 64'h0, 1, 0, 0);

        // Reset while full and presenting.
        for (int i = 0; i < 4; i++) cycle(1, 64'h800 + 64'(i * 16), 0, 0, 0);
        reset_cycle();
        rst = 0;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_level", level, 0);
        chk("midrst_ready", in_ready, 1'b1);
        chk("midrst_coal", coalesce_cnt, 0);
        chk("midrst_drop", drop_cnt, 0);

        // Randomized traffic with occasional flushes and resets.
        rfl = 0; flen = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                reset_cycle();
                rfl = 0;
                continue;
            end
            rfack = 0;
            if (!rfl && $urandom_range(0, 40) == 0) begin
                rfl = 1;
                flen = int'($urandom_range(1, 6));
            end else if (rfl) begin
                if (flen == 0) rfack = 1;
                else flen--;
            end
            ra = {($urandom_range(0, 1) == 0) ? 32'h0 : 32'hdead_beef,
                  28'($urandom_range(0, 9)), 4'($urandom)};
            cycle(bit'($urandom_range(0, 9) < 6), ra, bit'($urandom_range(0, 1)), rfl, rfack);
            if (rfack) rfl = 0;
        end
        cycle(0, 64'h0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
